wave_led_sequencer: RTL and testbench
=====================================

Name: wave_led_sequencer

Overview:
- Drives a 6-LED bank with short animated "wave" sequences.
- A rising edge on start_sequence latches the 3-bit pattern select and plays that pattern once, one frame per display tick, then blanks.
- Sits between board control logic (pattern select, trigger) and the on-board active-low LED pins.

Parameters:
- TICK_DIV, 4, clk cycles per display frame (display tick period); legal range ≥1.
- LED_N, 6, number of LEDs; fixed at 6 for this revision.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- signal  input  3  pattern select; sampled only on the start edge.
- start_sequence  input  1  trigger, synchronous to clk; a rising edge starts a sequence.
- LED  output  6  LED drive, active-low (0 = lit); LED[0] is leftmost.
- busy  output  1  high while a sequence is playing.

Behaviour:
- Internal signals:
  - l_out[5:0]: active-high frame.
  - LED = ~l_out, driven from a register (no combinational path from inputs).
  - display_clk: 1-cycle pulse every TICK_DIV cycles while busy.
- Reset (async, rst=1):
  - l_out=0, LED=6'b111111, busy=0.
  - Tick counter, step counter, latched pattern and start_prev all cleared.
- Edge detect:
  - start_prev is registered start_sequence.
  - Start when start_sequence=1 && start_prev=0 && busy=0.
  - Edges while busy are ignored; the sequence is not restarted.
  - signal changes during a sequence are ignored.
- On start (cycle N):
  - Latch pat=signal, step=0, tick counter=0, busy=1.
  - Frame 0 appears on LED at cycle N+1.
  - Each frame is held exactly TICK_DIV cycles.
  - display_clk pulses on the last cycle of each frame and advances step.
- Patterns (l_out frames, bit i = LED i):
  - pat 0: no-op. busy stays 0, LED stays all off.
  - pat 1, walk right: 000001, 000010, 000100, 001000, 010000, 100000. 6 frames.
  - pat 2, walk left: 100000, 010000, 001000, 000100, 000010, 000001. 6 frames.
  - pat 3, fill bar: 000001, 000011, 000111, 001111, 011111, 111111. 6 frames.
  - pat 4, bounce: bit 0..5 then 4..0, one-hot. 11 frames.
  - pat 5–7: treated as pat 0.
- End:
  - After the last frame's display_clk: l_out=0, busy=0, in the same cycle.
  - A new start edge is accepted from the following cycle on.
  - start_sequence held high across the end does not retrigger; it needs a new 0→1 transition.
- Reset mid-sequence aborts immediately: LED all off, busy=0.

Optional Feature:
- Macro WAVE_LED_LOOP_EN.
- Defined: if start_sequence is still 1 at the end of the last frame, the sequence restarts at frame 0 with the same latched pat, with no blank cycle. It stops (blank, busy=0) at the end of the first complete pass during which start_sequence is 0.
- Undefined: strictly one-shot as described above.

Test Plan (TICK_DIV=4):
- Reset: assert rst mid-run → LED=111111 and busy=0 asynchronously. After release, LED stays 111111.
- signal=1, pulse start → LED frames 111110, 111101, 111011, 110111, 101111, 011111.
  - Each frame is held 4 cycles; the first frame appears 1 cycle after the edge.
  - Then 111111 and busy=0 after 24 cycles.
- signal=2, start high; second start pulse and signal=3 mid-sequence → full walk-left (first frame 011111) unaffected, no restart.
- signal=3, start → cumulative bar, final frame LED=000000.
- signal=4, start → 11 one-hot frames, bounce back to bit 0.
- signal=0 or 6 → busy stays 0, LED stays 111111.
- start held high across end: one pass only (without WAVE_LED_LOOP_EN); repeats until released (with it).

Source files
------------

// File: rtl/wave_led_sequencer.sv
// wave_led_sequencer: plays a latched 6-LED wave pattern once, one frame per display tick.
// Optional WAVE_LED_LOOP_EN: repeats the pattern while start_sequence stays high at pass end.
module wave_led_sequencer #(
   parameter int TICK_DIV = 4,
   parameter int LED_N = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       signal,
   input  logic             start_sequence,
   output logic [LED_N-1:0] LED,
   output logic             busy
);
   localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   typedef enum logic {IDLE, PLAY} state_t;
   state_t state, state_n;
   logic [CW-1:0] tick_cnt, tick_cnt_n;
   logic [3:0] step, step_n;
   logic [2:0] pat, pat_n;
   logic [5:0] l_out, l_out_n;
   logic start_prev, start, display_clk, last, restart;

   function automatic logic [5:0] frame(input logic [2:0] p, input logic [3:0] s);
      return p == 3'd1 ? 6'b000001 << s :
             p == 3'd2 ? 6'b100000 >> s :
             p == 3'd3 ? ~(6'b111110 << s) :
             p == 3'd4 ? (s < 4'd6 ? 6'b000001 << s : 6'b000001 << (4'd10 - s)) : 6'b000000;
   endfunction

`ifdef WAVE_LED_LOOP_EN
   assign restart = start_sequence;
`else
   assign restart = 1'b0;
`endif

   // Patterns 0 and 5-7 are no-ops, so they never enter PLAY.
   assign start = start_sequence && !start_prev && state == IDLE && signal != 3'd0 && signal < 3'd5;
   assign display_clk = state == PLAY && tick_cnt == CW'(TICK_DIV - 1);
   assign last = step == (pat == 3'd4 ? 4'd10 : 4'd5);
   assign busy = state == PLAY;
   assign LED = ~l_out;

   always_comb begin
      state_n = state;
      tick_cnt_n = tick_cnt;
      step_n = step;
      pat_n = pat;
      l_out_n = l_out;
      if (start) begin
         state_n = PLAY;
         pat_n = signal;
         step_n = '0;
         tick_cnt_n = '0;
         l_out_n = frame(signal, 4'd0);
      end else if (state == PLAY) begin
         tick_cnt_n = display_clk ? '0 : tick_cnt + CW'(1);
         if (display_clk) begin
            step_n = last ? 4'd0 : step + 4'd1;
            l_out_n = last && !restart ? 6'b000000 : frame(pat, last ? 4'd0 : step + 4'd1);
            state_n = last && !restart ? IDLE : PLAY;
         end
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         tick_cnt <= '0;
         step <= '0;
         pat <= '0;
         l_out <= '0;
         start_prev <= 1'b0;
      end else begin
         state <= state_n;
         tick_cnt <= tick_cnt_n;
         step <= step_n;
         pat <= pat_n;
         l_out <= l_out_n;
         start_prev <= start_sequence;
      end
endmodule

// File: tb/tb_wave_led_sequencer.sv
// tb_wave_led_sequencer: directed and randomized checks of wave_led_sequencer against a frame-table model.
module tb_wave_led_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] signal = 3'd0;
   logic start_sequence = 1'b0;
   logic [5:0] LED;
   logic busy;
   int checks = 0;
   int errors = 0;

   wave_led_sequencer #(.TICK_DIV(4), .LED_N(6)) dut (
      .clk(clk), .rst(rst), .signal(signal), .start_sequence(start_sequence), .LED(LED), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Active-high frame i of pattern p, built from the pattern descriptions.
   function automatic logic [5:0] frame(input int p, input int i);
      int bnc[11] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0};
      logic [5:0] f = '0;
      if (p == 1) f[i] = 1'b1;
      else if (p == 2) f[5 - i] = 1'b1;
      else if (p == 3) for (int j = 0; j <= i; j++) f[j] = 1'b1;
      else if (p == 4) f[bnc[i]] = 1'b1;
      return f;
   endfunction

   function automatic int plen(input int p);
      return p == 4 ? 11 : (p >= 1 && p <= 3) ? 6 : 0;
   endfunction

   task automatic blank(input string tag, input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         chk({tag, "_led"}, LED, 6'b111111);
         chk({tag, "_busy"}, {5'b0, busy}, 6'd0);
      end
   endtask

   // Called at a negedge with start_sequence low for at least one edge.
   task automatic play(input int p, input bit disturb, input int passes, input bit hold_end);
      int n;
      n = plen(p) * 4;
      signal = p[2:0];
      start_sequence = 1'b1;
      for (int pass = 0; pass < passes; pass++)
         for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk($sformatf("p%0d_f%0d_led", p, k / 4), LED, ~frame(p, k / 4));
            chk($sformatf("p%0d_busy", p), {5'b0, busy}, 6'd1);
            if (k == n - 1) start_sequence = pass < passes - 1 ? 1'b1 : hold_end;
            else if (disturb) begin
               start_sequence = 1'($urandom_range(0, 1));
               signal = 3'($urandom);
            end else start_sequence = passes > 1 || hold_end;
         end
      blank($sformatf("p%0d_end", p), 3);
      start_sequence = 1'b0;
      @(negedge clk);
   endtask

   task automatic noop(input int p);
      signal = p[2:0];
      start_sequence = 1'b1;
      blank($sformatf("noop%0d", p), 4);
      start_sequence = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int p;
      @(negedge clk);
      chk("reset_led", LED, 6'b111111);
      chk("reset_busy", {5'b0, busy}, 6'd0);
      rst = 1'b0;
      @(negedge clk);
      play(1, 1'b0, 1, 1'b0);
      play(2, 1'b1, 1, 1'b0);
      play(3, 1'b0, 1, 1'b0);
      play(4, 1'b0, 1, 1'b0);
      noop(0);
      noop(6);
`ifdef WAVE_LED_LOOP_EN
      play(1, 1'b0, 3, 1'b0);
`else
      play(1, 1'b0, 1, 1'b1);
`endif
      // Async reset in the middle of a sequence.
      signal = 3'd3;
      start_sequence = 1'b1;
      @(negedge clk);
      start_sequence = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_reset_busy", {5'b0, busy}, 6'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_led", LED, 6'b111111);
      chk("async_rst_busy", {5'b0, busy}, 6'd0);
      @(negedge clk);
      rst = 1'b0;
      blank("post_rst", 3);
      repeat (20) begin
         p = int'($urandom_range(0, 7));
         if (plen(p) == 0) noop(p);
         else play(p, 1'($urandom_range(0, 1)), 1, 1'b0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
